// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, drives sync BIOS/IMEM reads,
// and pairs each returning word with its PC for decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        bios_dout,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               if_valid,
    output logic [31:0]        fetch_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] f_pc;
    logic [31:0] n_pc;
    logic        f_valid;
    logic        unused_low;

    // Stall re-presents the same address so the sync memory output holds.
    always_comb begin
        if (!rst_n)
            n_pc = RESET_PC;
        else if (redirect_valid)
            n_pc = {redirect_pc[31:2], 2'b00};
        else if (!f_valid || stall)
            n_pc = f_pc;
        else
            n_pc = f_pc + 32'd4;
    end

    assign unused_low = ^redirect_pc[1:0];

    assign bios_addr = n_pc[BIOS_AW+1:2];
    assign imem_addr = n_pc[IMEM_AW+1:2];

    assign if_pc    = f_pc;
    assign if_valid = f_valid & ~redirect_valid;
    assign if_inst  = !if_valid ? NOP
                    : (f_pc[30] ? bios_dout : imem_dout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_pc        <= RESET_PC;
            f_valid     <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            f_pc    <= n_pc;
            f_valid <= 1'b1;
            if (if_valid && !stall)
                fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
